// File: rtl/reg_write_arbiter_pkg.sv
// Shared config for the SPI register block: widths, address map and FSM encoding.
// The SPI peripheral imports the same package, so both sides agree on these values.
package reg_write_arbiter_pkg;

    localparam int CFG_W           = 8;
    localparam int CFG_MAX_ADDRESS = 4;
    localparam int CFG_AW          = 7;

    localparam logic [CFG_AW-1:0] DUTY_ADDR = 7'd4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic GNT_SPI = 1'b0;
    localparam logic GNT_SEQ = 1'b1;

    function automatic logic is_direct_reg(input logic [CFG_AW-1:0] addr);
        return addr < 7'd4;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request bundle for the two register writers: the SPI slave and the on-chip sequencer.
// The requesters use the master modport and the arbiter uses the slave modport.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int W = CFG_W
);
    logic              spi_wr_valid;
    logic [CFG_AW-1:0] spi_wr_addr;
    logic [W-1:0]      spi_wr_data;
    logic              spi_wr_ready;
    logic              seq_wr_valid;
    logic [CFG_AW-1:0] seq_wr_addr;
    logic [W-1:0]      seq_wr_data;
    logic              seq_wr_ready;

    modport master (
        output spi_wr_valid, spi_wr_addr, spi_wr_data,
        output seq_wr_valid, seq_wr_addr, seq_wr_data,
        input  spi_wr_ready, seq_wr_ready
    );

    modport slave (
        input  spi_wr_valid, spi_wr_addr, spi_wr_data,
        input  seq_wr_valid, seq_wr_addr, seq_wr_data,
        output spi_wr_ready, seq_wr_ready
    );
endinterface

// File: rtl/reg_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. On a tie it grants the input that was not granted last.
// After reset the pointer holds "sequencer last", so SPI wins the first tie.
module rr_arb2
    import reg_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output logic       gnt_o
);
    logic last_q;

    always_comb begin
        gnt_vld_o = en_i && (|req_i);
        gnt_o     = (req_i == 2'b11) ? ~last_q : req_i[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            last_q <= GNT_SEQ;
        else if (gnt_vld_o) last_q <= gnt_o;
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates SPI and sequencer writes into the config register file.
// The PWM duty register is double-buffered and takes its new value at the period boundary.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int W           = CFG_W,
    parameter int MAX_ADDRESS = CFG_MAX_ADDRESS
)(
    input  logic                 clk,
    input  logic                 rst,
    reg_write_arbiter_if.slave   wr,
    input  logic                 pwm_period_end,
    input  logic                 clr_err,
    output logic [W-1:0]         en_reg_out_7_0,
    output logic [W-1:0]         en_reg_out_15_8,
    output logic [W-1:0]         en_reg_pwm_7_0,
    output logic [W-1:0]         en_reg_pwm_15_8,
    output logic [W-1:0]         pwm_duty_cycle,
    output logic                 duty_pending,
    output logic                 addr_err
);
    localparam logic [CFG_AW-1:0] MAX_A = CFG_AW'(MAX_ADDRESS);

    logic [0:0]        state_q, state_d;
    logic              gnt_q;
    logic              gnt_vld, gnt;
    logic              commit;
    logic [CFG_AW-1:0] sel_addr;
    logic [W-1:0]      sel_data;
    logic              in_range;
    logic [3:0][W-1:0] regs_q;
    logic [W-1:0]      shadow_q;
    logic [W-1:0]      duty_q;
    logic              pending_q;
    logic              err_q;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({wr.seq_wr_valid, wr.spi_wr_valid}),
        .en_i      (state_q == ST_IDLE),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_vld) state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_SPI;
        end else begin
            state_q <= state_d;
            if (gnt_vld) gnt_q <= gnt;
        end
    end

    // Address/data are sampled during ACK, when the requester is still holding them.
    always_comb begin
        commit   = (state_q == ST_ACK);
        sel_addr = (gnt_q == GNT_SEQ) ? wr.seq_wr_addr : wr.spi_wr_addr;
        sel_data = (gnt_q == GNT_SEQ) ? wr.seq_wr_data : wr.spi_wr_data;
        in_range = (sel_addr <= MAX_A);
    end

    assign wr.spi_wr_ready = commit && (gnt_q == GNT_SPI);
    assign wr.seq_wr_ready = commit && (gnt_q == GNT_SEQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (commit && in_range && is_direct_reg(sel_addr)) begin
            regs_q[sel_addr[1:0]] <= sel_data;
        end
    end

    // On a coincident commit and period end, the old shadow goes live and the new data stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            duty_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (pwm_period_end && pending_q) begin
                duty_q    <= shadow_q;
                pending_q <= 1'b0;
            end
            if (commit && in_range && (sel_addr == DUTY_ADDR)) begin
                shadow_q  <= sel_data;
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err_q <= 1'b0;
        else if (commit && !in_range) err_q <= 1'b1;
        else if (clr_err)             err_q <= 1'b0;
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = duty_q;
    assign duty_pending    = pending_q;
    assign addr_err        = err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: handshake timing, round-robin, duty shadowing,
// out-of-range handling and reset during ACK, with hand-computed expected values.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_period_end = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       duty_pending, addr_err;
    int         n_cmp = 0;
    int         n_err = 0;

    reg_write_arbiter_if #(.W(8)) wr();

    reg_write_arbiter #(.W(8), .MAX_ADDRESS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr              (wr),
        .pwm_period_end  (pwm_period_end),
        .clr_err         (clr_err),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .duty_pending    (duty_pending),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] r0, r1, r2, r3, duty,
                             input logic pend, err);
        check({tag, ".r0"},   32'(en_reg_out_7_0),  32'(r0));
        check({tag, ".r1"},   32'(en_reg_out_15_8), 32'(r1));
        check({tag, ".r2"},   32'(en_reg_pwm_7_0),  32'(r2));
        check({tag, ".r3"},   32'(en_reg_pwm_15_8), 32'(r3));
        check({tag, ".duty"}, 32'(pwm_duty_cycle),  32'(duty));
        check({tag, ".pend"}, 32'(duty_pending),    32'(pend));
        check({tag, ".err"},  32'(addr_err),        32'(err));
    endtask

    // Single requester write: raise valid, expect its ready in the ACK cycle, then drop.
    task automatic do_write(input string tag, input bit is_seq, input logic [6:0] a,
                            input logic [7:0] d);
        if (is_seq) begin
            wr.seq_wr_valid = 1'b1; wr.seq_wr_addr = a; wr.seq_wr_data = d;
        end else begin
            wr.spi_wr_valid = 1'b1; wr.spi_wr_addr = a; wr.spi_wr_data = d;
        end
        tick();
        check({tag, ".rdy"},   32'(is_seq ? wr.seq_wr_ready : wr.spi_wr_ready), 32'd1);
        check({tag, ".other"}, 32'(is_seq ? wr.spi_wr_ready : wr.seq_wr_ready), 32'd0);
        tick();
        wr.spi_wr_valid = 1'b0;
        wr.seq_wr_valid = 1'b0;
        check({tag, ".rdy_off"}, 32'(wr.spi_wr_ready | wr.seq_wr_ready), 32'd0);
    endtask

    task automatic pulse_pwm();
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
    endtask

    initial begin
        wr.spi_wr_valid = 1'b0; wr.spi_wr_addr = '0; wr.spi_wr_data = '0;
        wr.seq_wr_valid = 1'b0; wr.seq_wr_addr = '0; wr.seq_wr_data = '0;

        tick(); tick();
        check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset.rdy", 32'(wr.spi_wr_ready | wr.seq_wr_ready), 32'd0);
        rst = 1'b0;
        tick();

        // SPI addr 2: ready in ACK, register visible two cycles after valid
        wr.spi_wr_valid = 1'b1; wr.spi_wr_addr = 7'd2; wr.spi_wr_data = 8'hA5;
        tick();
        check("spi2.rdy", 32'(wr.spi_wr_ready), 32'd1);
        check("spi2.seq_rdy", 32'(wr.seq_wr_ready), 32'd0);
        check("spi2.not_yet", 32'(en_reg_pwm_7_0), 32'h00);
        tick();
        wr.spi_wr_valid = 1'b0;
        check("spi2.rdy_off", 32'(wr.spi_wr_ready), 32'd0);
        check("spi2.val", 32'(en_reg_pwm_7_0), 32'hA5);

        // Both requesting from reset: SPI first, then sequencer
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        wr.spi_wr_valid = 1'b1; wr.spi_wr_addr = 7'd0; wr.spi_wr_data = 8'h11;
        wr.seq_wr_valid = 1'b1; wr.seq_wr_addr = 7'd1; wr.seq_wr_data = 8'h22;
        tick();
        check("rr.a.spi_rdy", 32'(wr.spi_wr_ready), 32'd1);
        check("rr.a.seq_rdy", 32'(wr.seq_wr_ready), 32'd0);
        tick();
        wr.spi_wr_valid = 1'b0;
        check("rr.a.r0", 32'(en_reg_out_7_0), 32'h11);
        check("rr.gap.rdy", 32'(wr.spi_wr_ready | wr.seq_wr_ready), 32'd0);
        tick();
        check("rr.b.seq_rdy", 32'(wr.seq_wr_ready), 32'd1);
        check("rr.b.spi_rdy", 32'(wr.spi_wr_ready), 32'd0);
        tick();
        wr.seq_wr_valid = 1'b0;
        check_all("rr.end", 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Duty write is shadowed until the period boundary
        do_write("duty80", 1'b1, 7'd4, 8'h80);
        check("duty80.pend", 32'(duty_pending), 32'd1);
        check("duty80.hold", 32'(pwm_duty_cycle), 32'h00);
        tick(); tick();
        check("duty80.hold2", 32'(pwm_duty_cycle), 32'h00);
        pulse_pwm();
        check("duty80.live", 32'(pwm_duty_cycle), 32'h80);
        check("duty80.clr", 32'(duty_pending), 32'd0);
        check("duty80.err", 32'(addr_err), 32'd0);
        pulse_pwm();
        check("duty.idle_pulse", 32'(pwm_duty_cycle), 32'h80);

        // Coincident commit and period end: old shadow goes live, new stays pending
        do_write("duty20", 1'b1, 7'd4, 8'h20);
        check("duty20.pend", 32'(duty_pending), 32'd1);
        wr.seq_wr_valid = 1'b1; wr.seq_wr_addr = 7'd4; wr.seq_wr_data = 8'h40;
        tick();
        check("duty40.rdy", 32'(wr.seq_wr_ready), 32'd1);
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
        wr.seq_wr_valid = 1'b0;
        check("coinc.duty", 32'(pwm_duty_cycle), 32'h20);
        check("coinc.pend", 32'(duty_pending), 32'd1);
        pulse_pwm();
        check("coinc.next", 32'(pwm_duty_cycle), 32'h40);
        check("coinc.pend0", 32'(duty_pending), 32'd0);

        // Out-of-range write still handshakes, data dropped, sticky error
        do_write("oor9", 1'b0, 7'd9, 8'hFF);
        check_all("oor9", 8'h11, 8'h22, 8'h00, 8'h00, 8'h40, 1'b0, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr.err", 32'(addr_err), 32'd0);

        // First invalid address coincident with clr_err: error wins
        wr.spi_wr_valid = 1'b1; wr.spi_wr_addr = 7'd5; wr.spi_wr_data = 8'h77;
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wr.spi_wr_valid = 1'b0;
        check("oor5.err_wins", 32'(addr_err), 32'd1);
        check_all("oor5", 8'h11, 8'h22, 8'h00, 8'h00, 8'h40, 1'b0, 1'b1);

        // Reset during ACK aborts the write
        wr.spi_wr_valid = 1'b1; wr.spi_wr_addr = 7'd3; wr.spi_wr_data = 8'h5A;
        tick();
        check("rst_ack.rdy", 32'(wr.spi_wr_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_ack", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_ack.rdy0", 32'(wr.spi_wr_ready | wr.seq_wr_ready), 32'd0);
        tick();
        wr.spi_wr_valid = 1'b0;
        rst = 1'b0;
        tick(); tick();
        check("rst_ack.r3", 32'(en_reg_pwm_15_8), 32'h00);
        do_write("rereq", 1'b0, 7'd3, 8'h5A);
        check("rereq.r3", 32'(en_reg_pwm_15_8), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, meaning config register data width.
REQ-002 SHALL have parameter MAX_ADDRESS, default 4, meaning highest valid register address.
REQ-003 SHALL have ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- spi_wr_valid  in  1  SPI-side write request
- spi_wr_addr  in  7  SPI write address
- spi_wr_data  in  W  SPI write data
- spi_wr_ready  out  1  SPI write accepted
- seq_wr_valid  in  1  on-chip sequencer write request
- seq_wr_addr  in  7  sequencer write address
- seq_wr_data  in  W  sequencer write data
- seq_wr_ready  out  1  sequencer write accepted
- pwm_period_end  in  1  one-cycle pulse at PWM period boundary
- clr_err  in  1  clears addr_err
- en_reg_out_7_0  out  W  register 0
- en_reg_out_15_8  out  W  register 1
- en_reg_pwm_7_0  out  W  register 2
- en_reg_pwm_15_8  out  W  register 3
- pwm_duty_cycle  out  W  register 4, active copy
- duty_pending  out  1  shadow duty not yet applied
- addr_err  out  1  sticky out-of-range write flag

Function
REQ-004 SHALL implement FSM states IDLE and ACK; IDLE->ACK when any valid is high; ACK->IDLE unconditionally.
REQ-005 SHALL, in IDLE with one valid high, register a grant to that requester.
REQ-006 SHALL, in IDLE with both valids high, grant round-robin: the requester not granted last; after reset, SPI wins first.
REQ-007 SHALL drive the granted requester's ready high for exactly the ACK cycle; the other ready stays low.
REQ-008 SHALL commit the granted addr/data sampled during ACK; requesters hold valid/addr/data stable until ready.
REQ-009 SHALL make writes to addresses 0-3 visible on outputs the cycle after ACK (valid-to-output latency 2 cycles).
REQ-010 SHALL route writes to address 4 into a shadow register and set duty_pending in the cycle after ACK.
REQ-011 SHALL copy shadow to pwm_duty_cycle and clear duty_pending on pwm_period_end when duty_pending is set.
REQ-012 SHALL, when address-4 commit and pwm_period_end coincide, apply the old shadow, capture the new data, and leave duty_pending set.
REQ-013 SHALL, for addresses above MAX_ADDRESS, still complete the ACK handshake, discard the data, and set addr_err.
REQ-014 SHALL clear addr_err on clr_err; a coincident out-of-range commit wins (addr_err stays 1).
REQ-015 SHALL sustain one accepted write per 2 cycles; a waiting requester waits at most one other grant.

Reset
REQ-016 SHALL, on rst assertion, asynchronously force FSM to IDLE, both readies 0, all registers, shadow, and pwm_duty_cycle to 0, duty_pending 0, addr_err 0, round-robin pointer to SPI-first.
REQ-017 SHALL drop an in-flight grant aborted by reset mid-ACK without writing; the requester re-requests after reset.

Structure
REQ-018 SHALL take W, MAX_ADDRESS, address width 7, and FSM state encoding from the shared config package used by the SPI peripheral.
REQ-019 SHALL contain one sub-module, rr_arb2 (two-input round-robin arbiter with last-grant pointer); register file and shadow logic stay in the top.

Verification
REQ-020 SPI writes addr 2 data 0xA5 -> spi_wr_ready one cycle, en_reg_pwm_7_0=0xA5 two cycles after valid.
REQ-021 Both valid from reset (SPI addr 0 0x11, seq addr 1 0x22) -> SPI granted first, seq next; outputs 0x11 and 0x22; ready pulses never overlap.
REQ-022 Seq writes addr 4 0x80 -> duty_pending=1, pwm_duty_cycle stays 0 until pwm_period_end, then 0x80 and duty_pending=0.
REQ-023 Addr-4 commit 0x40 coincident with pwm_period_end while shadow holds 0x20 -> pwm_duty_cycle=0x20, duty_pending=1; next pulse -> 0x40.
REQ-024 SPI writes addr 9 data 0xFF -> ready pulses, no output changes, addr_err=1; clr_err -> addr_err=0.
REQ-025 Assert rst during ACK of addr 3 write 0x5A -> all outputs 0, en_reg_pwm_15_8 remains 0 after release.
